// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator.
//   - pattern mode encodings
//   - default geometry / colour depth
//   - colour constants expressed as per-channel levels, so they map
//     onto any COLOR_W
//   - bouncing-box axis state and its one-frame step function
package vga_pkg;

    localparam int COLOR_W_DEF  = 4;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_BOX      = 2'd3
    } mode_t;

    // Channel level: off, full scale, or MSB-only (mid-grey).
    typedef enum logic [1:0] {
        LVL_ZERO = 2'd0,
        LVL_FULL = 2'd1,
        LVL_HALF = 2'd2
    } lvl_t;

    typedef struct packed {
        lvl_t r;
        lvl_t g;
        lvl_t b;
    } colour_t;

    localparam colour_t BLACK = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_ZERO};
    localparam colour_t WHITE = '{r: LVL_FULL, g: LVL_FULL, b: LVL_FULL};
    localparam colour_t BLUE  = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_FULL};
    localparam colour_t GREY  = '{r: LVL_HALF, g: LVL_HALF, b: LVL_HALF};

    typedef struct packed {
        logic [9:0] pos;
        logic       dir_pos;
    } axis_t;

    // One frame of motion on one axis. At a wall the direction flips and
    // the same frame already moves one pixel away from the wall.
    function automatic axis_t axis_step(input axis_t a, input logic [9:0] lim);
        axis_t n;
        n = a;
        if (a.dir_pos) begin
            if (a.pos == lim) begin
                n.dir_pos = 1'b0;
                n.pos     = a.pos - 10'd1;
            end else begin
                n.pos     = a.pos + 10'd1;
            end
        end else begin
            if (a.pos == 10'd0) begin
                n.dir_pos = 1'b1;
                n.pos     = a.pos + 10'd1;
            end else begin
                n.pos     = a.pos - 10'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vga_pattern_generator_if.sv
// Pattern-select request channel (valid/ready).
//   mode_req   : requested pattern
//   mode_valid : request valid, held by the requester until accepted
//   mode_ready : generator can take a request
// master = requester, slave = pattern generator.
interface vga_pattern_generator_if;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;

    modport master (output mode_req, output mode_valid, input mode_ready);
    modport slave  (input mode_req, input mode_valid, output mode_ready);
endinterface

// File: rtl/vga_bounce_box.sv
// Bouncing-box position state, advanced by one pixel per axis on each
// frame-start strobe.
//   clk, rst     : pixel clock, async active-low reset
//   fs           : frame-start strobe (one cycle)
//   box_x, box_y : top-left corner of the box
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

    axis_t ax;
    axis_t ay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ax <= '{pos: 10'd0, dir_pos: 1'b1};
            ay <= '{pos: 10'd0, dir_pos: 1'b1};
        end else if (fs) begin
            ax <= axis_step(ax, X_MAX);
            ay <= axis_step(ay, Y_MAX);
        end
    end

    assign box_x = ax.pos;
    assign box_y = ay.pos;

endmodule

// File: rtl/vga_pattern_generator.sv
// VGA test-pattern generator, placed after the display timing controller.
// Turns raw syncs / active flag / pixel coordinates into registered RGB
// with sync and data-enable delayed to match (2-clock pipeline). The
// pattern is chosen over a valid/ready channel and only switches at frame
// start, so a frame is never torn between patterns.
//
// Ports:
//   clk, rst          : pixel clock, async active-low reset
//   hs_in, vs_in      : syncs from the timing controller (active low)
//   active_in         : pixel is in the active area
//   x_in, y_in        : pixel coordinates (meaningful when active_in = 1)
//   mode_bus          : pattern request channel (slave side)
//   hs_out, vs_out    : syncs delayed by 2 clocks
//   de_out            : data enable delayed by 2 clocks
//   r_out/g_out/b_out : pixel colour, zero outside the active area
//   frame_cnt         : frames since reset, wraps at 256
//
// Build option VGA_PATGEN_BOUNCE_EN: when defined, mode 3 is an animated
// bouncing box; otherwise mode 3 is solid mid-grey and no box state exists.
//
// Request handshake states:
//   state      | meaning
//   HS_IDLE    | no pending request, mode_ready = 1
//   HS_PENDING | request held, waits for next frame start to become current
module vga_pattern_generator
    import vga_pkg::*;
#(
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hs_in,
    input  logic                    vs_in,
    input  logic                    active_in,
    input  logic [9:0]              x_in,
    input  logic [9:0]              y_in,
    vga_pattern_generator_if.slave  mode_bus,
    output logic                    hs_out,
    output logic                    vs_out,
    output logic                    de_out,
    output logic [COLOR_W-1:0]      r_out,
    output logic [COLOR_W-1:0]      g_out,
    output logic [COLOR_W-1:0]      b_out,
    output logic [7:0]              frame_cnt
);

    localparam int BAR_W = H_ACTIVE / 8;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    // Place a 4-bit value at the MSB end of a COLOR_W channel.
    function automatic logic [COLOR_W-1:0] fit4(input logic [3:0] v);
        logic [COLOR_W+3:0] wide;
        wide = {v, {COLOR_W{1'b0}}};
        return wide[COLOR_W+3 -: COLOR_W];
    endfunction

    function automatic logic [COLOR_W-1:0] lvl_to_val(input lvl_t l);
        logic [COLOR_W-1:0] v;
        v = '0;
        case (l)
            LVL_FULL: v = '1;
            LVL_HALF: v[COLOR_W-1] = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    // ---------------- frame start, handshake, frame counter ----------------
    logic      vs_prev;
    logic      fs;
    hs_state_t hs_state;
    hs_state_t hs_state_nxt;
    logic      accept;
    logic      commit;
    mode_t     mode_pend;
    mode_t     mode_cur;

    assign fs = ~vs_in & vs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_state <= HS_IDLE;
        end else begin
            hs_state <= hs_state_nxt;
        end
    end

    // A request accepted in the frame-start cycle lands in PENDING and so
    // only becomes current at the following frame start.
    always_comb begin
        hs_state_nxt = hs_state;
        accept       = 1'b0;
        commit       = 1'b0;
        case (hs_state)
            HS_IDLE: begin
                if (mode_bus.mode_valid) begin
                    accept       = 1'b1;
                    hs_state_nxt = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (fs) begin
                    commit       = 1'b1;
                    hs_state_nxt = HS_IDLE;
                end
            end
            default: hs_state_nxt = HS_IDLE;
        endcase
    end

    assign mode_bus.mode_ready = (hs_state == HS_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_prev   <= 1'b1;
            mode_pend <= MODE_BARS;
            mode_cur  <= MODE_BARS;
            frame_cnt <= 8'd0;
        end else begin
            vs_prev <= vs_in;
            if (accept) begin
                mode_pend <= mode_t'(mode_bus.mode_req);
            end
            if (commit) begin
                mode_cur <= mode_pend;
            end
            if (fs) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // ---------------- stage 1: syncs and pattern selectors ----------------
    logic [2:0] bar_idx;
    logic       hs_s1;
    logic       vs_s1;
    logic       de_s1;
    logic [2:0] bar_s1;
    logic       chk_s1;
    logic [3:0] grad_r_s1;
    logic [3:0] grad_g_s1;

    // Bar index = number of bar boundaries at or left of x.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, x_in} >= 11'(k * BAR_W)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
            de_s1     <= 1'b0;
            bar_s1    <= 3'd0;
            chk_s1    <= 1'b0;
            grad_r_s1 <= 4'd0;
            grad_g_s1 <= 4'd0;
        end else begin
            hs_s1     <= hs_in;
            vs_s1     <= vs_in;
            de_s1     <= active_in;
            bar_s1    <= bar_idx;
            chk_s1    <= x_in[5] ^ y_in[5];
            grad_r_s1 <= x_in[9:6];
            grad_g_s1 <= y_in[8:5];
        end
    end

`ifdef VGA_PATGEN_BOUNCE_EN
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       box_hit;
    logic       box_hit_s1;

    vga_bounce_box #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_bounce_box (
        .clk   (clk),
        .rst   (rst),
        .fs    (fs),
        .box_x (box_x),
        .box_y (box_y)
    );

    assign box_hit = ({1'b0, x_in} >= {1'b0, box_x}) &&
                     ({1'b0, x_in} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                     ({1'b0, y_in} >= {1'b0, box_y}) &&
                     ({1'b0, y_in} <  {1'b0, box_y} + 11'(BOX_SIZE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            box_hit_s1 <= 1'b0;
        end else begin
            box_hit_s1 <= box_hit;
        end
    end
`else
    // Without the box, the upper/lower y bits and the box size go unused.
    localparam int unused_box_size = BOX_SIZE;
    logic unused_y;
    assign unused_y = ^{y_in[9], y_in[4:0]};
`endif

    // ---------------- stage 2: colour mux and output registers ----------------
    logic [2:0]         bar_v;
    colour_t            colour;
    logic [COLOR_W-1:0] r_nxt;
    logic [COLOR_W-1:0] g_nxt;
    logic [COLOR_W-1:0] b_nxt;

    // Bars run white..black left to right, so the colour code is 7 - index.
    assign bar_v = ~bar_s1;

    always_comb begin
        colour = BLACK;
        r_nxt  = '0;
        g_nxt  = '0;
        b_nxt  = '0;
        case (mode_cur)
            MODE_BARS: begin
                colour.r = bar_v[2] ? LVL_FULL : LVL_ZERO;
                colour.g = bar_v[1] ? LVL_FULL : LVL_ZERO;
                colour.b = bar_v[0] ? LVL_FULL : LVL_ZERO;
            end
            MODE_CHECKER: colour = chk_s1 ? WHITE : BLACK;
`ifdef VGA_PATGEN_BOUNCE_EN
            MODE_BOX: colour = box_hit_s1 ? WHITE : BLUE;
`else
            MODE_BOX: colour = GREY;
`endif
            default: colour = BLACK;
        endcase
        if (de_s1) begin
            if (mode_cur == MODE_GRADIENT) begin
                r_nxt = fit4(grad_r_s1);
                g_nxt = fit4(grad_g_s1);
                b_nxt = fit4(frame_cnt[7:4]);
            end else begin
                r_nxt = lvl_to_val(colour.r);
                g_nxt = lvl_to_val(colour.g);
                b_nxt = lvl_to_val(colour.b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_out <= 1'b1;
            vs_out <= 1'b1;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            hs_out <= hs_s1;
            vs_out <= vs_s1;
            de_out <= de_s1;
            r_out  <= r_nxt;
            g_out  <= g_nxt;
            b_out  <= b_nxt;
        end
    end

endmodule

// File: tb/tb_vga_pattern_generator.sv
`timescale 1ns/1ps
module tb_vga_pattern_generator;

    localparam int CW = 4;
    localparam int HA = 640;
    localparam int VA = 480;
    localparam int BS = 32;
    localparam logic [14:0] RST_EXP = 15'h6000; // hs=1 vs=1 de=0 rgb=0

    typedef struct {
        int x;
        int y;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hs_in = 1'b1;
    logic          vs_in = 1'b0;
    logic          active_in = 1'b0;
    logic [9:0]    x_in = '0;
    logic [9:0]    y_in = '0;
    logic          hs_out;
    logic          vs_out;
    logic          de_out;
    logic [CW-1:0] r_out;
    logic [CW-1:0] g_out;
    logic [CW-1:0] b_out;
    logic [7:0]    frame_cnt;

    vga_pattern_generator_if mode_bus();

    vga_pattern_generator #(
        .COLOR_W  (CW),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .BOX_SIZE (BS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .active_in (active_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .mode_bus  (mode_bus),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic        m_vs_prev;
    logic [7:0]  m_fc;
    logic [1:0]  m_mode;
    logic        m_pend;
    logic [1:0]  m_pm;
    int          m_bx, m_by;
    bit          m_dx, m_dy;
    int          fs_seen;
    bit          req_valid;
    logic [1:0]  req_mode;
    logic [14:0] exp_q[$];
    pix_t        pix_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y);
        logic [9:0]  xv;
        logic [9:0]  yv;
        logic [2:0]  v;
        logic [11:0] c;
        xv = 10'(x);
        yv = 10'(y);
        case (m_mode)
            2'd0: begin
                v = 3'(7 - x / (HA / 8));
                c = {{4{v[2]}}, {4{v[1]}}, {4{v[0]}}};
            end
            2'd1: c = (xv[5] ^ yv[5]) ? 12'hFFF : 12'h000;
            2'd2: c = {xv[9:6], yv[8:5], m_fc[7:4]};
            default: begin
`ifdef VGA_PATGEN_BOUNCE_EN
                c = (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS) ? 12'hFFF : 12'h00F;
`else
                c = 12'h888;
`endif
            end
        endcase
        return c;
    endfunction

    task automatic model_reset();
        m_vs_prev = 1'b1;
        m_fc      = 8'd0;
        m_mode    = 2'd0;
        m_pend    = 1'b0;
        m_pm      = 2'd0;
        m_bx      = 0;
        m_by      = 0;
        m_dx      = 1'b1;
        m_dy      = 1'b1;
        fs_seen   = 0;
        req_valid = 1'b0;
        req_mode  = 2'd0;
        exp_q.delete();
    endtask

    // Advance the model by the cycle whose inputs were just driven and push
    // the output expected two clocks later.
    task automatic model_step(input logic h, input logic v, input logic a, input int x, input int y);
        logic fs;
        logic rdy_old;
        fs        = !v && m_vs_prev;
        m_vs_prev = v;
        rdy_old   = !m_pend;
        if (fs && m_pend) begin
            m_mode = m_pm;
            m_pend = 1'b0;
        end
        if (req_valid && rdy_old) begin
            m_pend    = 1'b1;
            m_pm      = req_mode;
            req_valid = 1'b0;
        end
        if (fs) begin
            m_fc = m_fc + 8'd1;
            fs_seen++;
            if (m_dx) begin
                if (m_bx == HA - BS) begin m_dx = 1'b0; m_bx--; end else m_bx++;
            end else begin
                if (m_bx == 0) begin m_dx = 1'b1; m_bx++; end else m_bx--;
            end
            if (m_dy) begin
                if (m_by == VA - BS) begin m_dy = 1'b0; m_by--; end else m_by++;
            end else begin
                if (m_by == 0) begin m_dy = 1'b1; m_by++; end else m_by--;
            end
        end
        exp_q.push_back({h, v, a, a ? exp_rgb(x, y) : 12'h000});
    endtask

    task automatic tick(input logic h, input logic v, input logic a, input int x, input int y);
        logic [14:0] e;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : RST_EXP;
        check_eq("pix", {hs_out, vs_out, de_out, r_out, g_out, b_out}, e);
        check_eq("ready", mode_bus.mode_ready, !m_pend);
        check_eq("frame_cnt", frame_cnt, m_fc);
        hs_in               = h;
        vs_in               = v;
        active_in           = a;
        x_in                = 10'(x);
        y_in                = 10'(y);
        mode_bus.mode_req   = req_mode;
        mode_bus.mode_valid = req_valid;
        model_step(h, v, a, x, y);
    endtask

    function automatic int rnd10();
        return int'($urandom_range(0, 1023));
    endfunction

    task automatic fill_box_pix();
        pix_q.delete();
        pix_q.push_back('{x: m_bx, y: m_by});
        pix_q.push_back('{x: m_bx + BS - 1, y: m_by + BS - 1});
        if (m_bx > 0)        pix_q.push_back('{x: m_bx - 1, y: m_by});
        if (m_bx + BS < HA)  pix_q.push_back('{x: m_bx + BS, y: m_by});
        if (m_by + BS < VA)  pix_q.push_back('{x: m_bx, y: m_by + BS});
    endtask

    // vsync (FS on first cycle), one hsync pulse, then the queued pixels.
    task automatic run_frame(input int req_pix, input logic [1:0] req_m, input bit box_pix);
        tick(1'b1, 1'b0, 1'b0, rnd10(), rnd10());
        tick(1'b1, 1'b0, 1'b0, rnd10(), rnd10());
        tick(1'b0, 1'b1, 1'b0, rnd10(), rnd10());
        tick(1'b1, 1'b1, 1'b0, rnd10(), rnd10());
        tick(1'b1, 1'b1, 1'b0, rnd10(), rnd10());
        if (box_pix) fill_box_pix();
        foreach (pix_q[i]) begin
            if (i == req_pix) begin
                req_valid = 1'b1;
                req_mode  = req_m;
            end
            tick(1'b1, 1'b1, 1'b1, pix_q[i].x, pix_q[i].y);
        end
        tick(1'b1, 1'b1, 1'b0, rnd10(), rnd10());
        tick(1'b1, 1'b1, 1'b0, rnd10(), rnd10());
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(RST_EXP);
        model_step(hs_in, vs_in, active_in, int'(x_in), int'(y_in));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sync_de"}, {hs_out, vs_out, de_out}, 3'b110);
        check_eq({tag, "_rgb"}, {r_out, g_out, b_out}, 12'h000);
        check_eq({tag, "_fc"}, frame_cnt, 8'd0);
        check_eq({tag, "_ready"}, mode_bus.mode_ready, 1'b1);
    endtask

    task automatic load_pix(input int xs[], input int ys[]);
        pix_q.delete();
        foreach (xs[i]) pix_q.push_back('{x: xs[i], y: ys[i]});
    endtask

    initial begin
        model_reset();
        mode_bus.mode_req   = 2'd0;
        mode_bus.mode_valid = 1'b0;

        // reset held, vs_in low so the first cycle after release is an FS
        repeat (3) @(negedge clk);
        check_reset_outputs("rst1");
        release_rst();
        tick(1'b1, 1'b1, 1'b0, 0, 0);

        // bars, boundaries on both sides of each edge
        load_pix('{0, 79, 80, 159, 160, 320, 400, 480, 560, 639},
                 '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10});
        run_frame(-1, 2'd0, 1'b0);
        // mid-frame request for checker; rest of frame stays bars
        run_frame(3, 2'd1, 1'b0);
        load_pix('{0, 32, 0, 32, 63, 95}, '{0, 0, 32, 32, 100, 479});
        run_frame(-1, 2'd0, 1'b0);
        // request presented in the FS cycle: waits a whole frame
        req_valid = 1'b1;
        req_mode  = 2'd2;
        run_frame(-1, 2'd0, 1'b0);
        load_pix('{0, 639, 320, 100}, '{0, 479, 240, 300});
        run_frame(-1, 2'd0, 1'b0);
        // gradient across the frame_cnt wrap 255 -> 0
        load_pix('{200}, '{150});
        while (fs_seen < 262) run_frame(-1, 2'd0, 1'b0);
        // switch to mode 3
        run_frame(0, 2'd3, 1'b0);
`ifdef VGA_PATGEN_BOUNCE_EN
        while (fs_seen < 620) run_frame(-1, 2'd0, 1'b1);
`else
        load_pix('{0, 300, 639}, '{0, 200, 479});
        run_frame(-1, 2'd0, 1'b0);
        run_frame(-1, 2'd0, 1'b0);
`endif

        // asynchronous reset in the middle of active video
        tick(1'b1, 1'b1, 1'b1, 12, 12);
        tick(1'b1, 1'b1, 1'b1, 13, 12);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst2");
        model_reset();
        hs_in               = 1'b1;
        vs_in               = 1'b0;
        active_in           = 1'b0;
        mode_bus.mode_valid = 1'b0;
        repeat (2) @(negedge clk);
        release_rst();
        tick(1'b1, 1'b1, 1'b0, 0, 0);
        load_pix('{0, 80, 639}, '{5, 5, 5});
        run_frame(-1, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
